sdiv_amisha: RTL and testbench



---
 rtl/sdiv_amisha.sv | 165 ++++++++++++++++
 tb/tb_sdiv_amisha.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdiv_amisha.sv
// Sequential signed/unsigned restoring divider: W-bit operands, start/ready/done_tick handshake.
// Optional abort input enabled by defining SDIV_ABORT_EN.
module sdiv_amisha #(
  parameter int W    = 16,
  parameter int CBIT = 5
) (
  input  logic         clk_amisha,
  input  logic         rst_n_amisha,
  input  logic         start_amisha,
  input  logic         signed_amisha,
  input  logic [W-1:0] dvnd_amisha,
  input  logic [W-1:0] dvsr_amisha,
`ifdef SDIV_ABORT_EN
  input  logic         abort_amisha,
`endif
  output logic         ready_amisha,
  output logic         done_tick_amisha,
  output logic         div_zero_amisha,
  output logic         ovf_amisha,
  output logic [W-1:0] quo_amisha,
  output logic [W-1:0] rmd_amisha
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OP    = 3'd1,
    S_LAST  = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   rh_q, rh_d, rl_q, rl_d, d_q, d_d;
  logic [CBIT-1:0] n_q, n_d;
  logic           sq_q, sq_d, sr_q, sr_d, ovfp_q, ovfp_d;
  logic [W-1:0]   quo_q, quo_d, rmd_q, rmd_d;
  logic           dz_q, dz_d, ovf_q, ovf_d;

  logic           abort;
  logic [W-1:0]   mag_dvnd, mag_dvsr, rh_tmp;
  logic           q_bit;

`ifdef SDIV_ABORT_EN
  assign abort = abort_amisha;
`else
  assign abort = 1'b0;
`endif

  assign mag_dvnd = (signed_amisha && dvnd_amisha[W-1]) ? -dvnd_amisha : dvnd_amisha;
  assign mag_dvsr = (signed_amisha && dvsr_amisha[W-1]) ? -dvsr_amisha : dvsr_amisha;
  assign q_bit    = (rh_q >= d_q);
  assign rh_tmp   = q_bit ? (rh_q - d_q) : rh_q;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    rh_d    = rh_q;
    rl_d    = rl_q;
    d_d     = d_q;
    n_d     = n_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    ovfp_d  = ovfp_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_amisha) begin
          // The first shift is folded into the accept edge so that W-1 OP
          // cycles plus LAST consume all W dividend bits.
          d_d    = mag_dvsr;
          rh_d   = {{(W-1){1'b0}}, mag_dvnd[W-1]};
          rl_d   = {mag_dvnd[W-2:0], 1'b0};
          n_d    = CBIT'(W-1);
          sq_d   = signed_amisha & (dvnd_amisha[W-1] ^ dvsr_amisha[W-1]);
          sr_d   = signed_amisha & dvnd_amisha[W-1];
          ovfp_d = signed_amisha && (dvnd_amisha == {1'b1, {(W-1){1'b0}}})
                   && (dvsr_amisha == '1);
          if (dvsr_amisha == '0) begin
            quo_d   = '1;
            rmd_d   = dvnd_amisha;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_OP;
          end
        end
      end
      S_OP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          rl_d = {rl_q[W-2:0], q_bit};
          rh_d = {rh_tmp[W-2:0], rl_q[W-1]};
          n_d  = n_q - 1'b1;
          if (n_q == CBIT'(1)) state_d = S_LAST;
        end
      end
      S_LAST: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          rl_d    = {rl_q[W-2:0], q_bit};
          rh_d    = rh_tmp;
          state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          quo_d   = sq_q ? -rl_q : rl_q;
          rmd_d   = sr_q ? -rh_q : rh_q;
          ovf_d   = ovfp_q;
          dz_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q <= S_IDLE;
      rh_q    <= '0;
      rl_q    <= '0;
      d_q     <= '0;
      n_q     <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      ovfp_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rh_q    <= rh_d;
      rl_q    <= rl_d;
      d_q     <= d_d;
      n_q     <= n_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      ovfp_q  <= ovfp_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready_amisha     = (state_q == S_IDLE);
  assign done_tick_amisha = (state_q == S_DONE);
  assign div_zero_amisha  = dz_q;
  assign ovf_amisha       = ovf_q;
  assign quo_amisha       = quo_q;
  assign rmd_amisha       = rmd_q;

endmodule

// File: tb/tb_sdiv_amisha.sv
// Self-checking bench for sdiv_amisha: directed cases plus a short random run,
// expected results queued at launch and compared when done_tick is seen.
`timescale 1ns/1ps
module tb_sdiv_amisha;
  localparam int W    = 16;
  localparam int CBIT = 5;
  localparam int LAT  = W + 2;

  logic         clk_amisha = 1'b0;
  logic         rst_n_amisha, start_amisha, signed_amisha;
  logic [W-1:0] dvnd_amisha, dvsr_amisha;
  logic         ready_amisha, done_tick_amisha, div_zero_amisha, ovf_amisha;
  logic [W-1:0] quo_amisha, rmd_amisha;
`ifdef SDIV_ABORT_EN
  logic         abort_amisha;
`endif

  sdiv_amisha #(.W(W), .CBIT(CBIT)) dut (
    .clk_amisha       (clk_amisha),
    .rst_n_amisha     (rst_n_amisha),
    .start_amisha     (start_amisha),
    .signed_amisha    (signed_amisha),
    .dvnd_amisha      (dvnd_amisha),
    .dvsr_amisha      (dvsr_amisha),
`ifdef SDIV_ABORT_EN
    .abort_amisha     (abort_amisha),
`endif
    .ready_amisha     (ready_amisha),
    .done_tick_amisha (done_tick_amisha),
    .div_zero_amisha  (div_zero_amisha),
    .ovf_amisha       (ovf_amisha),
    .quo_amisha       (quo_amisha),
    .rmd_amisha       (rmd_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  typedef struct packed {
    logic [W-1:0] quo;
    logic [W-1:0] rmd;
    logic         dz;
    logic         ovf;
  } exp_t;

  exp_t         sb_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] last_quo    = '0;
  logic [W-1:0] last_rmd    = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dz, input logic ovf);
    exp_t e;
    e.quo = q; e.rmd = r; e.dz = dz; e.ovf = ovf;
    return e;
  endfunction

  // Reference behaviour from language arithmetic (signed / and % truncate toward zero).
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = '0;
    if (b == '0) begin
      e.quo = '1; e.rmd = a; e.dz = 1'b1;
    end else if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      e.quo = {1'b1, {(W-1){1'b0}}}; e.rmd = '0; e.ovf = 1'b1;
    end else if (sgn) begin
      e.quo = $signed(a) / $signed(b);
      e.rmd = $signed(a) % $signed(b);
    end else begin
      e.quo = a / b;
      e.rmd = a % b;
    end
    return e;
  endfunction

  // Drives one start pulse; returns at the negedge of cycle 1 after the accept edge.
  task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input exp_t e);
    @(negedge clk_amisha);
    check("ready_before_start", ready_amisha, 1'b1);
    signed_amisha = sgn; dvnd_amisha = a; dvsr_amisha = b; start_amisha = 1'b1;
    if (push) sb_q.push_back(e);
    @(negedge clk_amisha);
    start_amisha = 1'b0;
  endtask

  // Waits (bounded) for done_tick starting in cycle 1; optionally pokes start at poke_cyc.
  task automatic wait_done(input int exp_lat, input int poke_cyc, input bit post);
    int   cyc = 1;
    bit   seen = 1'b0;
    bit   rdy_bad = 1'b0;
    exp_t e;
    while (1) begin
      if (ready_amisha !== 1'b0) rdy_bad = 1'b1;
      if (done_tick_amisha === 1'b1) begin seen = 1'b1; break; end
      if (cyc >= 100) break;
      if (poke_cyc != 0 && cyc == poke_cyc) begin
        check("hold_quo_busy", quo_amisha, last_quo);
        check("hold_rmd_busy", rmd_amisha, last_rmd);
        start_amisha = 1'b1; signed_amisha = 1'b1;
        dvnd_amisha = 16'h0F0F; dvsr_amisha = 16'h0003;
      end
      if (poke_cyc != 0 && cyc == poke_cyc + 1) start_amisha = 1'b0;
      @(negedge clk_amisha);
      cyc++;
    end
    check("done_seen", seen, 1'b1);
    check("latency", cyc, exp_lat);
    check("ready_low_busy", rdy_bad, 1'b0);
    check("sb_nonempty", (sb_q.size() > 0), 1'b1);
    if (seen && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("quo", quo_amisha, e.quo);
      check("rmd", rmd_amisha, e.rmd);
      check("div_zero", div_zero_amisha, e.dz);
      check("ovf", ovf_amisha, e.ovf);
      last_quo = e.quo;
      last_rmd = e.rmd;
    end
    if (post) begin
      @(negedge clk_amisha);
      check("ready_after_done", ready_amisha, 1'b1);
      check("done_one_cycle", done_tick_amisha, 1'b0);
    end
  endtask

  task automatic no_done_for(input int n, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_amisha);
      if (done_tick_amisha !== 1'b0) got = 1'b1;
    end
    check(tag, got, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic         sgn;
    logic [W-1:0] a, b;
    rst_n_amisha = 1'b0; start_amisha = 1'b0; signed_amisha = 1'b0;
    dvnd_amisha = '0; dvsr_amisha = '0;
`ifdef SDIV_ABORT_EN
    abort_amisha = 1'b0;
`endif
    repeat (2) @(negedge clk_amisha);
    rst_n_amisha = 1'b1;
    @(negedge clk_amisha);
    check("rst_ready", ready_amisha, 1'b1);
    check("rst_done", done_tick_amisha, 1'b0);
    check("rst_dz", div_zero_amisha, 1'b0);
    check("rst_ovf", ovf_amisha, 1'b0);
    check("rst_quo", quo_amisha, '0);
    check("rst_rmd", rmd_amisha, '0);

    // Basic unsigned, then sign combinations
    launch(1'b0, 16'd1000, 16'd7, 1'b1, mk(16'd142, 16'd6, 1'b0, 1'b0));
    wait_done(LAT, 0, 1'b1);
    launch(1'b1, 16'hFFF9, 16'd2, 1'b1, mk(16'hFFFD, 16'hFFFF, 1'b0, 1'b0));
    wait_done(LAT, 0, 1'b1);
    launch(1'b1, 16'd7, 16'hFFFE, 1'b1, mk(16'hFFFD, 16'h0001, 1'b0, 1'b0));
    wait_done(LAT, 0, 1'b1);
    launch(1'b0, 16'hFFF9, 16'd2, 1'b1, mk(16'h7FFC, 16'h0001, 1'b0, 1'b0));
    wait_done(LAT, 0, 1'b1);

    // Divide by zero in both modes, then a normal op clears div_zero
    launch(1'b0, 16'h1234, 16'h0000, 1'b1, mk(16'hFFFF, 16'h1234, 1'b1, 1'b0));
    wait_done(1, 0, 1'b1);
    launch(1'b1, 16'h1234, 16'h0000, 1'b1, mk(16'hFFFF, 16'h1234, 1'b1, 1'b0));
    wait_done(1, 0, 1'b1);
    launch(1'b0, 16'd9, 16'd3, 1'b1, mk(16'd3, 16'd0, 1'b0, 1'b0));
    wait_done(LAT, 0, 1'b1);

    // Signed overflow corner and its unsigned counterpart
    launch(1'b1, 16'h8000, 16'hFFFF, 1'b1, mk(16'h8000, 16'h0000, 1'b0, 1'b1));
    wait_done(LAT, 0, 1'b1);
    launch(1'b0, 16'h8000, 16'hFFFF, 1'b1, mk(16'h0000, 16'h8000, 1'b0, 1'b0));
    wait_done(LAT, 0, 1'b1);

    // start pulsed while busy is ignored; previous results hold during the op
    launch(1'b0, 16'd1000, 16'd7, 1'b1, mk(16'd142, 16'd6, 1'b0, 1'b0));
    wait_done(LAT, 5, 1'b1);

    // start held through DONE is taken on the following IDLE cycle
    @(negedge clk_amisha);
    signed_amisha = 1'b0; dvnd_amisha = 16'd100; dvsr_amisha = 16'd9; start_amisha = 1'b1;
    sb_q.push_back(mk(16'd11, 16'd1, 1'b0, 1'b0));
    sb_q.push_back(mk(16'd11, 16'd1, 1'b0, 1'b0));
    @(negedge clk_amisha);
    wait_done(LAT, 0, 1'b0);
    @(negedge clk_amisha);
    check("held_start_idle", ready_amisha, 1'b1);
    @(negedge clk_amisha);
    check("held_start_reaccept", ready_amisha, 1'b0);
    start_amisha = 1'b0;
    wait_done(LAT, 0, 1'b1);

    // Asynchronous reset in cycle 9 of an operation
    launch(1'b0, 16'd1000, 16'd7, 1'b0, '0);
    repeat (8) @(negedge clk_amisha);
    rst_n_amisha = 1'b0;
    #1;
    check("midrst_ready", ready_amisha, 1'b1);
    check("midrst_done", done_tick_amisha, 1'b0);
    check("midrst_quo", quo_amisha, '0);
    check("midrst_rmd", rmd_amisha, '0);
    @(negedge clk_amisha);
    rst_n_amisha = 1'b1;
    last_quo = '0; last_rmd = '0;
    no_done_for(25, "midrst_no_done");

`ifdef SDIV_ABORT_EN
    launch(1'b1, 16'hFF00, 16'd7, 1'b1, model(1'b1, 16'hFF00, 16'd7));
    wait_done(LAT, 0, 1'b1);
    launch(1'b0, 16'd5000, 16'd3, 1'b0, '0);
    repeat (5) @(negedge clk_amisha);
    abort_amisha = 1'b1;
    @(negedge clk_amisha);
    abort_amisha = 1'b0;
    check("abort_ready", ready_amisha, 1'b1);
    check("abort_hold_quo", quo_amisha, last_quo);
    check("abort_hold_rmd", rmd_amisha, last_rmd);
    no_done_for(25, "abort_no_done");
    launch(1'b0, 16'd5000, 16'd3, 1'b1, mk(16'd1666, 16'd2, 1'b0, 1'b0));
    wait_done(LAT, 0, 1'b1);
`endif

    // Short random run against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      sgn = 1'(($urandom_range(0, 1)));
      a   = W'($urandom);
      b   = (i == 5) ? '0 : ((i % 3 == 0) ? W'($urandom_range(1, 40)) : W'($urandom));
      launch(sgn, a, b, 1'b1, model(sgn, a, b));
      wait_done((b == '0) ? 1 : LAT, 0, 1'b1);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
